// File: rtl/vga_timing_gen.sv
// Raster scan generator for the VGA path: coordinates, blank, syncs, strobes and a frame counter.
// Every output is registered from the next-state decode so that coordinates and decode always agree.
module vga_timing_gen #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic       line_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    // 11-bit limits so a total of exactly 1024 cannot wrap to zero
    localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    function automatic logic below(input logic [9:0] v, input logic [10:0] lim);
        return {1'b0, v} < lim;
    endfunction

    function automatic logic sync_level(input logic [9:0] v, input logic [10:0] lo,
                                        input logic [10:0] hi);
        return (!below(v, lo) && below(v, hi)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    endfunction

    logic       x_wrap;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       line_nxt;
    logic       frame_nxt;

    // Next-state coordinates and strobes, decoded in parallel with the counters
    always_comb begin
        x_wrap    = (DrawX == H_LAST);
        x_nxt     = x_wrap ? 10'd0 : DrawX + 10'd1;
        y_nxt     = DrawY;
        if (x_wrap) begin
            y_nxt = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
        end
        line_nxt  = (x_nxt == 10'd0);
        frame_nxt = line_nxt && (y_nxt == 10'd0);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= H_LAST;
            DrawY       <= V_LAST;
            blank       <= 1'b0;
            hs          <= ~SYNC_ACTIVE;
            vs          <= ~SYNC_ACTIVE;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            frame_count <= 8'd0;
        end else if (en) begin
            DrawX       <= x_nxt;
            DrawY       <= y_nxt;
            blank       <= below(x_nxt, H_VIS) && below(y_nxt, V_VIS);
            hs          <= sync_level(x_nxt, HS_BEG, HS_END);
            vs          <= sync_level(y_nxt, VS_BEG, VS_END);
            frame_start <= frame_nxt;
            line_start  <= line_nxt;
            if (frame_nxt) begin
                frame_count <= frame_count + 8'd1;
            end
        end else begin
            // Frozen scan: hold everything but never repeat a strobe
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end
    end

endmodule
